// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the mtm ALU operation controller:
// opcodes, controller states, frame and CTL layouts, and the CRC3 helper.
package mtm_alu_pkg;

  // Legal ALU opcodes; every other encoding is reported as an op error.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // CRC3 generator x^3 + x + 1 (the x^3 term is implicit in the shift).
  localparam logic [3:0] CRC3_POLY      = 4'b1011;
  localparam int         CRC3_DATA_BITS = 37;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_RESP_OK  = 2'd2,
    ST_RESP_ERR = 2'd3
  } ctrl_state_e;

  // One buffered frame as delivered by the deserializer.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        err_data;
    logic        err_crc;
  } frame_t;

  // Error response CTL: every flag appears twice, then even parity over [7:1].
  typedef struct packed {
    logic is_err;
    logic data_hi;
    logic crc_hi;
    logic op_hi;
    logic data_lo;
    logic crc_lo;
    logic op_lo;
    logic parity;
  } err_ctl_t;

  // Success response CTL: leading zero, ALU flags, CRC3 of result and flags.
  typedef struct packed {
    logic       is_err;
    logic [3:0] flags;
    logic [2:0] crc;
  } ok_ctl_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Serial CRC3 over {c, 1'b0, flags}, MSB first, starting from 3'b000.
  function automatic logic [2:0] crc3_37(input logic [31:0] c, input logic [3:0] flags);
    logic [CRC3_DATA_BITS-1:0] data;
    logic [2:0]                crc;
    logic                      fb;
    data = {c, 1'b0, flags};
    crc  = 3'b000;
    for (int i = CRC3_DATA_BITS - 1; i >= 0; i--) begin
      fb  = crc[2] ^ data[i];
      crc = {crc[1:0], 1'b0} ^ ({3{fb}} & CRC3_POLY[2:0]);
    end
    return crc;
  endfunction

  function automatic err_ctl_t build_err_ctl(input logic d, input logic c, input logic o);
    err_ctl_t r;
    r.is_err  = 1'b1;
    r.data_hi = d;
    r.crc_hi  = c;
    r.op_hi   = o;
    r.data_lo = d;
    r.crc_lo  = c;
    r.op_lo   = o;
    r.parity  = ^{1'b1, d, c, o, d, c, o};
    return r;
  endfunction

endpackage

// File: rtl/mtm_alu_op_ctrl_if.sv
// Bus bundle around the operation controller: decoded-frame input,
// ALU issue/completion and the serializer response handshake.
// master = controller side, slave = deserializer/ALU/serializer side.
interface mtm_alu_op_ctrl_if;

  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        in_err_data;
  logic        in_err_crc;

  logic        alu_start;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [31:0] alu_c;
  logic [3:0]  alu_flags;

  logic        out_valid;
  logic        out_ready;
  logic        out_err;
  logic [31:0] out_c;
  logic [7:0]  out_ctl;

  logic        ovf;

  modport master (
    input  in_valid, in_a, in_b, in_op, in_err_data, in_err_crc,
    output alu_start, alu_a, alu_b, alu_op,
    input  alu_done, alu_c, alu_flags,
    output out_valid, out_err, out_c, out_ctl,
    input  out_ready,
    output ovf
  );

  modport slave (
    output in_valid, in_a, in_b, in_op, in_err_data, in_err_crc,
    input  alu_start, alu_a, alu_b, alu_op,
    output alu_done, alu_c, alu_flags,
    input  out_valid, out_err, out_c, out_ctl,
    output out_ready,
    input  ovf
  );

endinterface

// File: rtl/mtm_alu_frame_fifo.sv
// Small synchronous show-ahead FIFO for decoded frames.
// The head entry is visible combinationally so the controller can decide
// and issue in the same cycle it pops. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module mtm_alu_frame_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_op_ctrl.sv
// mtm ALU operation controller: buffers decoded frames, issues legal ones
// to the ALU with a start/done handshake (with timeout), and presents the
// {C, CTL} response to the serializer under valid/ready.
// Optional build macro MTM_ALU_OP_CTRL_STATS_EN adds saturating counters
// stat_ok / stat_err of accepted success / error responses.
module mtm_alu_op_ctrl
  import mtm_alu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef MTM_ALU_OP_CTRL_STATS_EN
  output logic [15:0]        stat_ok,
  output logic [15:0]        stat_err,
`endif
  mtm_alu_op_ctrl_if.master  bus
);

  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam int FW = $bits(frame_t);

  frame_t      in_frame;
  frame_t      head;
  logic [FW-1:0] fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        head_err_op;
  logic        head_err;
  ok_ctl_t     ok_ctl_next;
  logic        resp_accept;

  ctrl_state_e state_reg;
  logic [TW-1:0] timer_reg;
  logic        alu_start_reg;
  logic [31:0] alu_a_reg;
  logic [31:0] alu_b_reg;
  logic [2:0]  alu_op_reg;
  logic        out_valid_reg;
  logic        out_err_reg;
  logic [31:0] out_c_reg;
  logic [7:0]  out_ctl_reg;
  logic        ovf_reg;

  // Pack the incoming frame into the FIFO entry layout.
  always_comb begin
    in_frame          = '0;
    in_frame.a        = bus.in_a;
    in_frame.b        = bus.in_b;
    in_frame.op       = bus.in_op;
    in_frame.err_data = bus.in_err_data;
    in_frame.err_crc  = bus.in_err_crc;
  end

  mtm_alu_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .pop   (fifo_pop),
    .din   (in_frame),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head        = fifo_dout;
  assign fifo_pop    = (state_reg == ST_IDLE) && !fifo_empty;
  assign resp_accept = out_valid_reg && bus.out_ready;

  // Classify the head frame and pre-build the success CTL from the ALU result.
  always_comb begin
    head_err_op        = !op_is_legal(head.op);
    head_err           = head.err_data || head.err_crc || head_err_op;
    ok_ctl_next        = '0;
    ok_ctl_next.is_err = 1'b0;
    ok_ctl_next.flags  = bus.alu_flags;
    ok_ctl_next.crc    = crc3_37(bus.alu_c, bus.alu_flags);
  end

  // Sequencing FSM with registered ALU and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      timer_reg     <= '0;
      alu_start_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_op_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_err_reg   <= 1'b0;
      out_c_reg     <= '0;
      out_ctl_reg   <= '0;
    end else begin
      alu_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (head_err) begin
              out_valid_reg <= 1'b1;
              out_err_reg   <= 1'b1;
              out_c_reg     <= '0;
              out_ctl_reg   <= build_err_ctl(head.err_data, head.err_crc, head_err_op);
              state_reg     <= ST_RESP_ERR;
            end else begin
              alu_a_reg     <= head.a;
              alu_b_reg     <= head.b;
              alu_op_reg    <= head.op;
              alu_start_reg <= 1'b1;
              // The issue cycle itself is the first counted wait cycle.
              timer_reg     <= TW'(1);
              state_reg     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A completion in the timeout cycle still counts as success.
          if (bus.alu_done) begin
            out_valid_reg <= 1'b1;
            out_err_reg   <= 1'b0;
            out_c_reg     <= bus.alu_c;
            out_ctl_reg   <= ok_ctl_next;
            state_reg     <= ST_RESP_OK;
          end else if (timer_reg == TW'(ALU_TIMEOUT)) begin
            out_valid_reg <= 1'b1;
            out_err_reg   <= 1'b1;
            out_c_reg     <= '0;
            out_ctl_reg   <= build_err_ctl(1'b0, 1'b0, 1'b1);
            state_reg     <= ST_RESP_ERR;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_RESP_OK, ST_RESP_ERR: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            out_err_reg   <= 1'b0;
            out_c_reg     <= '0;
            out_ctl_reg   <= '0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Sticky overflow: a frame arrived while full and nothing left that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (bus.in_valid && fifo_full && !fifo_pop) begin
      ovf_reg <= 1'b1;
    end
  end

  assign bus.alu_start = alu_start_reg;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.alu_op    = alu_op_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_err   = out_err_reg;
  assign bus.out_c     = out_c_reg;
  assign bus.out_ctl   = out_ctl_reg;
  assign bus.ovf       = ovf_reg;

`ifdef MTM_ALU_OP_CTRL_STATS_EN
  logic [15:0] stat_ok_reg;
  logic [15:0] stat_err_reg;

  // Saturating counts of accepted responses, split by response type.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ok_reg  <= '0;
      stat_err_reg <= '0;
    end else if (resp_accept) begin
      if (!out_err_reg && (stat_ok_reg != 16'hFFFF)) begin
        stat_ok_reg <= stat_ok_reg + 16'd1;
      end
      if (out_err_reg && (stat_err_reg != 16'hFFFF)) begin
        stat_err_reg <= stat_err_reg + 16'd1;
      end
    end
  end

  assign stat_ok  = stat_ok_reg;
  assign stat_err = stat_err_reg;
`else
  // Handshake detect is only consumed by the statistics counters.
  logic unused_accept;
  assign unused_accept = resp_accept;
`endif

endmodule

// File: tb/tb_mtm_alu_op_ctrl.sv
// Scoreboard bench for mtm_alu_op_ctrl: stimulus pushes expected responses,
// an ALU responder plays back per-frame plans, and a monitor checks every
// accepted response and output stability while stalled.
module tb_mtm_alu_op_ctrl;

  localparam int DEPTH = 2;
  localparam int TO    = 16;

  typedef struct packed {
    logic        err;
    logic [31:0] c;
    logic [7:0]  ctl;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [5:0]  k;
    logic [31:0] c;
    logic [3:0]  flags;
    logic        abandon;
  } plan_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mtm_alu_op_ctrl_if bus_if();

`ifdef MTM_ALU_OP_CTRL_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_err;
`endif

  mtm_alu_op_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .ALU_TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef MTM_ALU_OP_CTRL_STATS_EN
    .stat_ok  (stat_ok),
    .stat_err (stat_err),
`endif
    .bus      (bus_if)
  );

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    hold_ready = 1'b0;

  task automatic check(input bit cond, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!cond) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: remainder of M(x)*x^3 divided by x^3+x+1, by long division.
  function automatic logic [2:0] crc_ref(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] m;
    m = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    end
    return m[2:0];
  endfunction

  function automatic logic [7:0] err_ref(input logic d, input logic c, input logic o);
    logic [6:0] hi;
    hi = {1'b1, d, c, o, d, c, o};
    return {hi, ^hi};
  endfunction

  function automatic logic legal_ref(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic d, input logic cr);
    @(posedge clk); #1;
    bus_if.in_a = a; bus_if.in_b = b; bus_if.in_op = op;
    bus_if.in_err_data = d; bus_if.in_err_crc = cr;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  // Queue expectations for one frame (k = cycles from alu_start to alu_done; k >= TO means late).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic d, input logic cr, input int k, input logic [31:0] c,
                       input logic [3:0] fl);
    exp_t  e;
    plan_t p;
    if (d || cr || !legal_ref(op)) begin
      e = '{err: 1'b1, c: 32'd0, ctl: err_ref(d, cr, !legal_ref(op))};
    end else begin
      p = '{a: a, b: b, op: op, k: 6'(k), c: c, flags: fl, abandon: 1'b0};
      plan_q.push_back(p);
      if (k >= TO) e = '{err: 1'b1, c: 32'd0, ctl: err_ref(1'b0, 1'b0, 1'b1)};
      else         e = '{err: 1'b0, c: c, ctl: {1'b0, fl, crc_ref(c, fl)}};
    end
    exp_q.push_back(e);
    send(a, b, op, d, cr);
  endtask

  task automatic wait_room();
    int n = 0;
    while (exp_q.size() >= DEPTH && n < 400) begin
      @(posedge clk); n++;
    end
    #1;
    check(exp_q.size() < DEPTH, "room_timeout", 64'(exp_q.size()), 64'(DEPTH - 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0) && n < 600) begin
      @(posedge clk); n++;
    end
    #1;
    check(exp_q.size() == 0, "drain_resp", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check(bus_if.out_valid == 1'b0, {tag, "_out_valid"}, 64'(bus_if.out_valid), 64'd0);
    check(bus_if.out_err == 1'b0, {tag, "_out_err"}, 64'(bus_if.out_err), 64'd0);
    check(bus_if.out_c == 32'd0, {tag, "_out_c"}, 64'(bus_if.out_c), 64'd0);
    check(bus_if.out_ctl == 8'd0, {tag, "_out_ctl"}, 64'(bus_if.out_ctl), 64'd0);
    check(bus_if.alu_start == 1'b0, {tag, "_alu_start"}, 64'(bus_if.alu_start), 64'd0);
    check({bus_if.alu_a, bus_if.alu_b} == 64'd0, {tag, "_alu_ab"}, {bus_if.alu_a, bus_if.alu_b}, 64'd0);
    check(bus_if.alu_op == 3'd0, {tag, "_alu_op"}, 64'(bus_if.alu_op), 64'd0);
    check(bus_if.ovf == 1'b0, {tag, "_ovf"}, 64'(bus_if.ovf), 64'd0);
  endtask

  // Serializer ready: random, or held low for the stall scenario.
  initial begin
    bus_if.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus_if.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
  end

  // Monitor: compares each accepted response and checks stall stability.
  initial begin
    exp_t        e;
    bit          pending = 1'b0;
    logic        prev_err;
    logic [31:0] prev_c;
    logic [7:0]  prev_ctl;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          check(bus_if.out_valid == 1'b1, "valid_held", 64'(bus_if.out_valid), 64'd1);
          check({bus_if.out_err, bus_if.out_c, bus_if.out_ctl} == {prev_err, prev_c, prev_ctl},
                "stall_stable", {bus_if.out_err, bus_if.out_c, bus_if.out_ctl}, {prev_err, prev_c, prev_ctl});
        end
        if (bus_if.out_valid && bus_if.out_ready) begin
          check(exp_q.size() != 0, "resp_expected", 64'(bus_if.out_ctl), 64'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(bus_if.out_err == e.err, "out_err", 64'(bus_if.out_err), 64'(e.err));
            check(bus_if.out_c == e.c, "out_c", 64'(bus_if.out_c), 64'(e.c));
            check(bus_if.out_ctl == e.ctl, "out_ctl", 64'(bus_if.out_ctl), 64'(e.ctl));
          end
          pending = 1'b0;
        end else if (bus_if.out_valid) begin
          pending  = 1'b1;
          prev_err = bus_if.out_err;
          prev_c   = bus_if.out_c;
          prev_ctl = bus_if.out_ctl;
        end else begin
          pending = 1'b0;
        end
      end
    end
  end

  // ALU responder: plays back the plan of each issued frame.
  initial begin
    plan_t p;
    bus_if.alu_done  = 1'b0;
    bus_if.alu_c     = '0;
    bus_if.alu_flags = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.alu_start) begin
        check(plan_q.size() != 0, "start_expected", 64'd1, 64'd0);
        if (plan_q.size() != 0) begin
          p = plan_q.pop_front();
          check(bus_if.alu_a == p.a, "alu_a", 64'(bus_if.alu_a), 64'(p.a));
          check(bus_if.alu_b == p.b, "alu_b", 64'(bus_if.alu_b), 64'(p.b));
          check(bus_if.alu_op == p.op, "alu_op", 64'(bus_if.alu_op), 64'(p.op));
          for (int i = 1; i <= int'(p.k); i++) begin
            @(posedge clk); #1;
            if (i == 1) check(bus_if.alu_start == 1'b0, "start_pulse", 64'(bus_if.alu_start), 64'd0);
            if (!p.abandon && i < TO)
              check(bus_if.out_valid == 1'b0, "valid_early", 64'(bus_if.out_valid), 64'd0);
            if (!p.abandon && i == TO)
              check(bus_if.out_valid && bus_if.out_err, "timeout_exact",
                    64'({bus_if.out_valid, bus_if.out_err}), 64'b11);
            if (i == int'(p.k)) begin
              bus_if.alu_done  = 1'b1;
              bus_if.alu_c     = p.c;
              bus_if.alu_flags = p.flags;
            end
          end
          @(posedge clk); #1;
          bus_if.alu_done = 1'b0;
          if (!p.abandon && int'(p.k) < TO)
            check(bus_if.out_valid && !bus_if.out_err, "done_latency",
                  64'({bus_if.out_valid, bus_if.out_err}), 64'b10);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    plan_t rp;
    int    n;
    bus_if.in_valid = 1'b0; bus_if.in_a = '0; bus_if.in_b = '0; bus_if.in_op = '0;
    bus_if.in_err_data = 1'b0; bus_if.in_err_crc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Directed: ADD with zero result, the three error codes, and a timeout.
    issue(32'd1, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b0, 3, 32'd0, 4'b1010);
    wait_room();
    exp_q.push_back('{err: 1'b1, c: 32'd0, ctl: 8'hC9});
    send($urandom, $urandom, 3'b000, 1'b1, 1'b0);
    wait_room();
    exp_q.push_back('{err: 1'b1, c: 32'd0, ctl: 8'hA5});
    send($urandom, $urandom, 3'b001, 1'b0, 1'b1);
    wait_room();
    exp_q.push_back('{err: 1'b1, c: 32'd0, ctl: 8'h93});
    send($urandom, $urandom, 3'b111, 1'b0, 1'b0);
    wait_room();
    issue($urandom, $urandom, 3'b101, 1'b0, 1'b0, TO, $urandom, 4'hF);
    drain();

    // Randomized frames, including done on the timeout boundary and late done.
    for (int f = 0; f < 60; f++) begin
      int r;
      int k;
      wait_room();
      r = $urandom_range(0, 9);
      k = (r < 2) ? TO - 1 : (r < 4) ? TO : $urandom_range(1, TO - 2);
      issue($urandom, $urandom, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
            k, $urandom, 4'($urandom_range(0, 15)));
    end
    drain();

    // Stall: three frames arrive while the first response is held.
    hold_ready = 1'b1;
    repeat (2) @(posedge clk);
    issue($urandom, $urandom, 3'b000, 1'b0, 1'b0, 2, $urandom, 4'b0011);
    n = 0;
    while (!bus_if.out_valid && n < 50) begin @(negedge clk); n++; end
    check(bus_if.out_valid == 1'b1, "stall_first_valid", 64'(bus_if.out_valid), 64'd1);
    check(bus_if.ovf == 1'b0, "ovf_before", 64'(bus_if.ovf), 64'd0);
    issue($urandom, $urandom, 3'b100, 1'b0, 1'b0, 4, $urandom, 4'b0100);
    issue($urandom, $urandom, 3'b001, 1'b1, 1'b0, 0, 32'd0, 4'd0);
    send($urandom, $urandom, 3'b101, 1'b0, 1'b0);
    check(bus_if.ovf == 1'b1, "ovf_after_drop", 64'(bus_if.ovf), 64'd1);
    repeat (4) @(posedge clk);
    hold_ready = 1'b0;
    drain();
    check(bus_if.ovf == 1'b1, "ovf_sticky", 64'(bus_if.ovf), 64'd1);

    // Reset while waiting on the ALU; its late done must be ignored.
    rp = '{a: 32'h1234_5678, b: 32'h0000_0042, op: 3'b100, k: 6'd3, c: 32'hDEAD_BEEF,
           flags: 4'b0001, abandon: 1'b1};
    plan_q.push_back(rp);
    send(32'h1234_5678, 32'h0000_0042, 3'b100, 1'b0, 1'b0);
    n = 0;
    while (!bus_if.alu_start && n < 50) begin @(negedge clk); n++; end
    check(bus_if.alu_start == 1'b1, "reset_start_seen", 64'(bus_if.alu_start), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("midreset");
    repeat (3) begin
      @(posedge clk); #1;
      check(bus_if.out_valid == 1'b0, "late_done_valid", 64'(bus_if.out_valid), 64'd0);
      check(bus_if.alu_start == 1'b0, "late_done_start", 64'(bus_if.alu_start), 64'd0);
    end

    // After reset: three successes and two errors.
    issue($urandom, $urandom, 3'b100, 1'b0, 1'b0, 2, $urandom, 4'b1000);
    wait_room();
    issue($urandom, $urandom, 3'b010, 1'b0, 1'b0, 0, 32'd0, 4'd0);
    wait_room();
    issue($urandom, $urandom, 3'b001, 1'b0, 1'b0, TO - 1, $urandom, 4'b0110);
    wait_room();
    issue($urandom, $urandom, 3'b000, 1'b0, 1'b1, 0, 32'd0, 4'd0);
    wait_room();
    issue($urandom, $urandom, 3'b101, 1'b0, 1'b0, 5, $urandom, 4'b1111);
    drain();
`ifdef MTM_ALU_OP_CTRL_STATS_EN
    check(stat_ok == 16'd3, "stat_ok", 64'(stat_ok), 64'd3);
    check(stat_err == 16'd2, "stat_err", 64'(stat_err), 64'd2);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
